instr_decode_buf: RTL and testbench

INSTR_DECODE_BUF -- requirements
Module: instr_decode_buf

---
 rtl/instr_decode_buf_pkg.sv | 23 ++
 rtl/signex6.sv | 9 +
 rtl/instr_decode_buf.sv | 86 ++++++++
 tb/tb_instr_decode_buf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/instr_decode_buf_pkg.sv
// rtl/instr_decode_buf_pkg.sv - shared field positions, widths and entry type for the decode buffer
package instr_decode_buf_pkg;

  localparam int INSTR_W   = 16;
  localparam int BUF_DEPTH = 2;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int RB_MSB   = 8;
  localparam int RB_LSB   = 6;
  localparam int RC_MSB   = 5;
  localparam int RC_LSB   = 3;
  localparam int IMM6_MSB = 5;
  localparam int IMM6_LSB = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } entry_t;

endpackage

// File: rtl/signex6.sv
// rtl/signex6.sv - sign-extends a 6-bit immediate to 16 bits
module signex6 (
  input  logic [5:0]  imm6,
  output logic [15:0] imm16
);

  assign imm16 = {{10{imm6[5]}}, imm6};

endmodule

// File: rtl/instr_decode_buf.sv
// rtl/instr_decode_buf.sv - 2-entry fetch-to-decode FIFO presenting decoded fields of the head word
module instr_decode_buf
  import instr_decode_buf_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INSTR_W-1:0] in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [2:0]         out_ra,
  output logic [2:0]         out_rb,
  output logic [2:0]         out_rc,
  output logic [5:0]         out_imm6,
  output logic [15:0]        out_imm16,
  output logic [INSTR_W-1:0] out_pc
);

  entry_t     mem [BUF_DEPTH];
  entry_t     head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] next_count;
  logic       push;
  logic       pop;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    next_count = count;
    if (push && !pop)
      next_count = count + 2'd1;
    else if (pop && !push)
      next_count = count - 2'd1;
  end

  // in_ready/out_valid are registered copies of the next count so neither
  // handshake output has a combinational path from the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= next_count;
      in_ready  <= (next_count != 2'(BUF_DEPTH));
      out_valid <= (next_count != 2'd0);
    end
  end

  assign head       = mem[rd_ptr];
  assign out_opcode = head.instr[OPC_MSB:OPC_LSB];
  assign out_ra     = head.instr[RA_MSB:RA_LSB];
  assign out_rb     = head.instr[RB_MSB:RB_LSB];
  assign out_rc     = head.instr[RC_MSB:RC_LSB];
  assign out_imm6   = head.instr[IMM6_MSB:IMM6_LSB];
  assign out_pc     = head.pc;

  signex6 u_signex6 (
    .imm6  (out_imm6),
    .imm16 (out_imm16)
  );

endmodule

// File: tb/tb_instr_decode_buf.sv
// tb/tb_instr_decode_buf.sv - directed self-checking bench for instr_decode_buf
module tb_instr_decode_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_ra;
  logic [2:0]  out_rb;
  logic [2:0]  out_rc;
  logic [5:0]  out_imm6;
  logic [15:0] out_imm16;
  logic [15:0] out_pc;

  int checks = 0;
  int errors = 0;

  instr_decode_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_ra     (out_ra),
    .out_rb     (out_rb),
    .out_rc     (out_rc),
    .out_imm6   (out_imm6),
    .out_imm16  (out_imm16),
    .out_pc     (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if ({out_opcode, out_ra, out_rb, out_rc, out_imm16, out_pc} !== 45'd0) begin
      errors++; $display("FAIL reset_fields got opc=%h imm16=%h pc=%h exp=0", out_opcode, out_imm16, out_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_push();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1A7F; in_pc = 16'h0040;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push1_valid got=%0b exp=1", out_valid); end
    checks++; if (out_opcode !== 4'h1 || out_ra !== 3'd5 || out_rb !== 3'd1 || out_rc !== 3'd7) begin
      errors++; $display("FAIL push1_regs got opc=%h ra=%0d rb=%0d rc=%0d exp opc=1 ra=5 rb=1 rc=7",
                         out_opcode, out_ra, out_rb, out_rc); end
    checks++; if (out_imm6 !== 6'h3F || out_imm16 !== 16'hFFFF) begin
      errors++; $display("FAIL push1_imm got imm6=%h imm16=%h exp 3f ffff", out_imm6, out_imm16); end
    checks++; if (out_pc !== 16'h0040) begin errors++; $display("FAIL push1_pc got=%h exp=0040", out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL push1_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h2E05; in_pc = 16'h0100;
    step();
    checks++; if (out_valid !== 1'b1 || out_imm6 !== 6'h05 || out_imm16 !== 16'h0005) begin
      errors++; $display("FAIL bp_first got valid=%0b imm6=%h imm16=%h exp 1 05 0005", out_valid, out_imm6, out_imm16); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%0b exp=1", in_ready); end
    in_instr = 16'h3123; in_pc = 16'h0102;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
    in_instr = 16'h4444; in_pc = 16'h0104;
    step();
    checks++; if (in_ready !== 1'b0 || out_pc !== 16'h0100) begin
      errors++; $display("FAIL bp_third got ready=%0b pc=%h exp 0 0100", in_ready, out_pc); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 16'h0102 || out_opcode !== 4'h3) begin
      errors++; $display("FAIL bp_pop1 got ready=%0b valid=%0b pc=%h opc=%h exp 1 1 0102 3",
                         in_ready, out_valid, out_pc, out_opcode); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_pop2 got=%0b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_third got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pc;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h5000; in_pc = 16'h0200;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = 16'h5000 + 16'(i + 1);
      in_pc    = 16'h0200 + 16'((i + 1) * 2);
      exp_pc   = 16'h0200 + 16'(i * 2);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== exp_pc || out_imm6 !== 6'(i)) begin
        errors++; $display("FAIL b2b_%0d got valid=%0b ready=%0b pc=%h imm6=%h exp 1 1 %h %h",
                           i, out_valid, in_ready, out_pc, out_imm6, exp_pc, 6'(i)); end
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0214 || out_imm6 !== 6'd10) begin
      errors++; $display("FAIL b2b_last got valid=%0b pc=%h imm6=%h exp 1 0214 0a", out_valid, out_pc, out_imm6); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h6001; in_pc = 16'h0300;
    step();
    in_instr = 16'h6002; in_pc = 16'h0302;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill got=%0b exp=0", in_ready); end
    flush = 1'b1; out_ready = 1'b1; in_instr = 16'h7777; in_pc = 16'h0304;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got valid=%0b ready=%0b exp 0 1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d got=%0b exp=0", i, out_valid); end
    end
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h8ABC; in_pc = 16'h0400;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0400 || out_opcode !== 4'h8) begin
      errors++; $display("FAIL flush_repush got valid=%0b pc=%h opc=%h exp 1 0400 8", out_valid, out_pc, out_opcode); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_instr = 16'h9155; in_pc = 16'h0500;
    step();
    in_instr = 16'h9166; in_pc = 16'h0502;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_prefill got ready=%0b valid=%0b exp 0 1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_handshake got valid=%0b ready=%0b exp 0 1", out_valid, in_ready); end
    checks++; if ({out_opcode, out_ra, out_rb, out_rc, out_imm6} !== 19'd0 || out_imm16 !== 16'h0000 || out_pc !== 16'h0000) begin
      errors++; $display("FAIL arst_fields got opc=%h imm16=%h pc=%h exp 0", out_opcode, out_imm16, out_pc); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
